// File: rtl/hex_display_if.sv
// Handshake and display bundle for the eight-digit multiplexed hex display driver.
// The master side loads values and controls blanking; the slave side drives the digit and segment lines.
interface hex_display_if;
  logic        load;
  logic [31:0] value;
  logic        blank;
  logic        load_ack;
  logic [7:0]  an;
  logic [6:0]  seg;

  modport master (
    output load,
    output value,
    output blank,
    input  load_ack,
    input  an,
    input  seg
  );

  modport slave (
    input  load,
    input  value,
    input  blank,
    output load_ack,
    output an,
    output seg
  );
endinterface

// File: rtl/hex_display_driver.sv
// Eight-digit multiplexed seven-segment hex display driver.
// It latches a 32-bit value on load and scans one digit every SCAN_DIV clocks, with optional leading-zero blanking.
module hex_display_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  hex_display_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    AN_OFF    = 8'hFF;
  localparam logic [6:0]    SEG_OFF   = 7'h7F;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [31:0]   shadow;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          load_ack_q;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A digit above 0 is a leading zero when it and every nibble above it are zero.
  function automatic logic lz_blanked(input logic [31:0] sh, input logic [2:0] k);
    logic [31:0] rest;
    rest = sh >> {k, 2'b00};
    return (LZ_BLANK != 0) && (k != 3'd0) && (rest == 32'd0);
  endfunction

  logic [3:0] cur_nib;
  assign cur_nib = shadow[{idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= 32'd0;
      presc      <= '0;
      idx        <= 3'd0;
      load_ack_q <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      load_ack_q <= bus.load;
      if (bus.load) begin
        shadow <= bus.value;
      end

      case (state)
        IDLE: begin
          presc <= '0;
          idx   <= 3'd0;
          if (bus.load) begin
            state <= SCAN;
          end
        end
        default: begin
          if (presc == PRESC_MAX) begin
            presc <= '0;
            idx   <= idx + 3'd1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
      endcase

      // Outputs reflect the registered index and shadow, so they trail any change by one cycle.
      if (state == IDLE || bus.blank || lz_blanked(shadow, idx)) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
      end else begin
        an_q  <= ~(8'b1 << idx);
        seg_q <= seg_decode(cur_nib);
      end
    end
  end

  assign bus.load_ack = load_ack_q;
  assign bus.an       = an_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: one instance without and one with leading-zero blanking,
// a directed vector table, hand-written corner sequences and a randomized run against a time-based model.
module tb_hex_display_driver;

  localparam int DIV = 4;
  localparam logic [15:0] DARK = {1'b0, 8'hFF, 7'h7F};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ld  [2];
  logic [31:0] val [2];
  logic        blk [2];

  hex_display_if if_a ();
  hex_display_if if_b ();

  assign if_a.load  = ld[0];
  assign if_a.value = val[0];
  assign if_a.blank = blk[0];
  assign if_b.load  = ld[1];
  assign if_b.value = val[1];
  assign if_b.blank = blk[1];

  hex_display_driver #(.SCAN_DIV(DIV), .LZ_BLANK(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  hex_display_driver #(.SCAN_DIV(DIV), .LZ_BLANK(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  logic [15:0] act [2];
  assign act[0] = {if_a.load_ack, if_a.an, if_a.seg};
  assign act[1] = {if_b.load_ack, if_b.an, if_b.seg};

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: the digit on show is derived from the number of cycles spent scanning.
  bit          m_scan [2];
  logic [31:0] m_sh   [2];
  int          m_t    [2];
  logic [15:0] exp_o  [2];

  function automatic logic [14:0] disp(input bit scan, input logic blk_i, input logic [31:0] sh,
                                       input int t, input bit lz);
    int          k;
    logic [31:0] rest;
    logic [7:0]  an_v;
    if (!scan || blk_i) return {8'hFF, 7'h7F};
    k    = (t / DIV) % 8;
    rest = sh >> (4 * k);
    if (lz && k != 0 && rest == 0) return {8'hFF, 7'h7F};
    an_v = 8'hFF;
    an_v[k] = 1'b0;
    return {an_v, seg_tab[rest[3:0]]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_scan[i] <= 1'b0;
        m_sh[i]   <= 32'd0;
        m_t[i]    <= 0;
        exp_o[i]  <= DARK;
      end else begin
        exp_o[i] <= {ld[i], disp(m_scan[i], blk[i], m_sh[i], m_t[i], i == 1)};
        if (ld[i]) m_sh[i] <= val[i];
        if (!m_scan[i]) begin
          if (ld[i]) begin
            m_scan[i] <= 1'b1;
            m_t[i]    <= 0;
          end
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        ld;
    logic [31:0] val;
    logic        blk;
    logic [15:0] exp;
  } vec_t;

  vec_t tv[$];

  initial begin
    vec_t        v;
    logic [6:0]  dseg [8];
    logic [7:0]  an_m;
    logic [7:0]  an_v;
    int          nidx;

    dseg = '{7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
             7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
    v = '{1'b1, 32'h01234567, 1'b0, {1'b1, 8'hFF, 7'h7F}};
    tv.push_back(v);
    for (int k = 0; k < 8; k++) begin
      an_m = 8'hFF;
      an_m[k] = 1'b0;
      for (int c = 0; c < DIV; c++) begin
        v = '{1'b0, 32'd0, 1'b0, {1'b0, an_m, dseg[k]}};
        tv.push_back(v);
      end
    end
    v = '{1'b0, 32'd0, 1'b0, {1'b0, 8'hFE, 7'b1111000}};
    tv.push_back(v);

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld[i] = 1'b0; val[i] = 32'd0; blk[i] = 1'b0;
    end
    @(negedge clk);
    step();
    step();
    chk("reset_a", act[0], DARK);
    chk("reset_b", act[1], DARK);
    rst_n = 1'b1;

    for (int n = 0; n < 100; n++) begin
      step();
      chk("idle_no_load", act[0], DARK);
    end

    // ---- table: first load and a full 8-digit scan on the non-blanking instance
    foreach (tv[j]) begin
      ld[0] = tv[j].ld; val[0] = tv[j].val; blk[0] = tv[j].blk;
      step();
      chk($sformatf("vec%0d", j), act[0], tv[j].exp);
    end
    ld[0] = 1'b0;

    // ---- leading-zero blanking
    ld[1] = 1'b1; val[1] = 32'h000000A5;
    step();
    ld[1] = 1'b0;
    chk("lz_ack", act[1][15], 1'b1);
    for (int n = 0; n < 8 * DIV * 2 + 2; n++) begin
      step();
      chk("lz_model", act[1], exp_o[1]);
      an_v = act[1][14:7];
      if (an_v == 8'hFE)      chk("lz_digit0", act[1][6:0], 7'b0010010);
      else if (an_v == 8'hFD) chk("lz_digit1", act[1][6:0], 7'b0001000);
      else                    chk("lz_an_off", an_v, 8'hFF);
    end

    // ---- blank held mid-scan, then resume
    step(); step();
    blk[0] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("blank_dark", act[0][14:0], DARK[14:0]);
    end
    blk[0] = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      chk("blank_resume", act[0], exp_o[0]);
    end

    // ---- load coinciding with a prescaler wrap
    for (int n = 0; n < DIV && (m_t[0] % DIV) != DIV - 1; n++) step();
    chk("wrap_reached", m_t[0] % DIV, DIV - 1);
    nidx = ((m_t[0] / DIV) + 1) % 8;
    ld[0] = 1'b1; val[0] = 32'hFFFFFFFF;
    step();
    ld[0] = 1'b0;
    chk("wrap_ack", act[0][15], 1'b1);
    step();
    an_m = 8'hFF;
    an_m[nidx] = 1'b0;
    chk("wrap_seg", act[0][6:0], 7'b0001110);
    chk("wrap_an", act[0][14:7], an_m);

    // ---- reset together with load during a scan
    step(); step();
    rst_n = 1'b0; ld[0] = 1'b1; val[0] = 32'h89ABCDEF;
    step();
    chk("rst_with_load", act[0], DARK);
    rst_n = 1'b1; ld[0] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      chk("post_rst_idle", act[0], DARK);
    end
    ld[0] = 1'b1; val[0] = 32'h89ABCDE2;
    step();
    ld[0] = 1'b0;
    chk("fresh_load_ack", act[0], {1'b1, 8'hFF, 7'h7F});
    step();
    chk("fresh_load_show", act[0], {1'b0, 8'hFE, 7'b0100100});

    // ---- randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        ld[i]  = ($urandom_range(0, 7) == 0);
        val[i] = $urandom >> (4 * $urandom_range(0, 8));
        if ($urandom_range(0, 15) == 0) blk[i] = ~blk[i];
      end
      step();
      chk("rand_a", act[0], exp_o[0]);
      chk("rand_b", act[1], exp_o[1]);
    end

    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

Interface
REQ-001 The module SHALL have a parameter SCAN_DIV, default 50000, giving the clock cycles per digit slot; legal range is 2 or more.
REQ-002 The module SHALL have a parameter LZ_BLANK, default 0, which enables leading-zero blanking when set to 1.
REQ-003 The module SHALL have one clock and a synchronous, active-low reset.
REQ-004 The module SHALL have the port clk, input, 1 bit, rising-edge system clock.
REQ-005 The module SHALL have the port rst_n, input, 1 bit, synchronous active-low reset.
REQ-006 The module SHALL have the port load, input, 1 bit, a one-cycle request to capture value.
REQ-007 The module SHALL have the port value, input, 32 bits, eight hex nibbles; nibble k is value[4k+3:4k].
REQ-008 The module SHALL have the port blank, input, 1 bit, which turns all digits off while high.
REQ-009 The module SHALL have the port load_ack, output, 1 bit, a one-cycle capture acknowledge.
REQ-010 The module SHALL have the port an, output, 8 bits, active-low digit enables; an[k] selects digit k.
REQ-011 The module SHALL have the port seg, output, 7 bits, active-low segments, bit6..bit0 = g,f,e,d,c,b,a.

Function
REQ-012 The module SHALL implement a two-state FSM, IDLE and SCAN; IDLE→SCAN occurs on the first cycle with load=1; there is no exit from SCAN except reset.
REQ-013 In IDLE, the outputs SHALL be an=8'hFF and seg=7'h7F.
REQ-014 On load=1, in any state, the module SHALL copy value into a 32-bit shadow register at that clock edge.
REQ-015 load_ack SHALL be 1 exactly in the cycle after each load=1 cycle; back-to-back loads SHALL produce back-to-back acks, with the last captured value winning.
REQ-016 In SCAN, a prescaler SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-017 At the wrap, the 3-bit digit index SHALL increment modulo 8, going 7→0.
REQ-018 Entry to SCAN SHALL start the cycle with prescaler=0 and index=0.
REQ-019 Outputs SHALL be registered, with a 1-cycle latency from an index or shadow change to an and seg.
REQ-020 an SHALL be one-hot low at bit index.
REQ-021 seg SHALL be the decode of shadow nibble [index].
REQ-022 The decode table for seg SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 With LZ_BLANK=1, any digit k>0 whose nibbles k..7 are all zero SHALL be blanked (an[k]=1, seg=7'h7F); digit 0 is never blanked by this rule.
REQ-024 With LZ_BLANK=0, all eight digits SHALL always be shown.
REQ-025 blank=1 SHALL force an=8'hFF and seg=7'h7F on the next cycle, while the prescaler, index and shadow keep running.
REQ-026 When blank falls, the display SHALL resume at the current index with no restart.
REQ-027 A load in the same cycle as a prescaler wrap SHALL apply both changes; the next cycle shows the new shadow nibble at the new index.
REQ-028 A load in SCAN SHALL NOT reset the prescaler or the index.

Reset
REQ-029 When rst_n=0 at a clock edge, the module SHALL set: state=IDLE, shadow=0, prescaler=0, index=0, load_ack=0, an=8'hFF, seg=7'h7F.
REQ-030 Reset SHALL override load in the same cycle, so no capture and no ack occur.
REQ-031 A reset in the middle of a scan SHALL abort immediately; the display stays dark until the next load.

Verification
REQ-032 The bench SHALL cover reset with no load for 100 cycles -> an=FF, seg=7F, load_ack=0 throughout.
REQ-033 The bench SHALL cover SCAN_DIV=4, load value=32'h01234567 -> load_ack=1 one cycle later; digit 0 shows seg=1111000 ("7") with an=FE; every 4 cycles an steps FD, FB … 7F and back to FE; digit 7 shows 1000000.
REQ-034 The bench SHALL cover LZ_BLANK=1, value=32'h000000A5 -> only an FE and FD ever go low; digit 1 shows 0001000 and digit 0 shows 0010010.
REQ-035 The bench SHALL cover blank held for 10 cycles mid-scan -> an=FF and seg=7F during the hold; after release, the index equals what it would be with no blank.
REQ-036 The bench SHALL cover load=1 coincident with a prescaler wrap, with the new value 32'hFFFFFFFF -> the next cycle shows 0001110 at the incremented index, and load_ack=1.
REQ-037 The bench SHALL cover rst_n=0 for 1 cycle during SCAN together with load=1 -> the next cycle shows an=FF and load_ack=0, and the module stays in IDLE until a fresh load.
